mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_load_extend.sv | 19 +
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic        rstEnable    = 1'b1;
  localparam logic        writeDisable = 1'b0;
  localparam logic [4:0]  regNOP       = 5'd0;
  localparam logic [31:0] ZERO32       = 32'h0;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of low-aligned load data; width 11 behaves as a word.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [1:0]  width,
  input  logic        sign_ext,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    case (width)
      WIDTH_BYTE: result = {{24{sign_ext & raw[7]}}, raw[7:0]};
      WIDTH_HALF: result = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default:    result = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: ALU pass-through, or one memory-controller request per load/store
// with a stall held until the controller's completion pulse.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 rdE_in,
  input  logic [REG_IDX_W-1:0] rdIdx_in,
  input  logic [DATA_W-1:0]    rdData_in,
  input  logic                 memLoad_in,
  input  logic                 memStore_in,
  input  logic [1:0]           memWidth_in,
  input  logic                 memSigned_in,
  input  logic [DATA_W-1:0]    memAddr_in,
  input  logic [DATA_W-1:0]    memData_in,
  output logic                 mcReq_out,
  output logic                 mcWrite_out,
  output logic [DATA_W-1:0]    mcAddr_out,
  output logic [1:0]           mcWidth_out,
  output logic [DATA_W-1:0]    mcData_out,
  input  logic                 mcDone_in,
  input  logic [DATA_W-1:0]    mcData_in,
  output logic                 rdE_out,
  output logic [REG_IDX_W-1:0] rdIdx_out,
  output logic [DATA_W-1:0]    rdData_out,
  output logic                 stallReq_out
);

  state_t            state, state_nxt;
  logic              mc_signed;
  logic [DATA_W-1:0] load_buf;
  logic [DATA_W-1:0] ext_data;
  logic              mem_op;

  assign mem_op = memLoad_in | memStore_in;

  load_extend u_ext (
    .width    (mcWidth_out),
    .sign_ext (mc_signed),
    .raw      (mcData_in),
    .result   (ext_data)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      mcReq_out   <= 1'b0;
      mcWrite_out <= 1'b0;
      mcAddr_out  <= '0;
      mcWidth_out <= WIDTH_BYTE;
      mcData_out  <= '0;
      mc_signed   <= 1'b0;
      load_buf    <= '0;
    end else if (rdy_in) begin
      state <= state_nxt;
      case (state)
        IDLE: if (mem_op) begin
          mcReq_out   <= 1'b1;
          mcWrite_out <= memStore_in;
          mcAddr_out  <= memAddr_in;
          // Illegal width 11 is forwarded as a word access.
          mcWidth_out <= (memWidth_in == 2'b11) ? WIDTH_WORD : memWidth_in;
          mcData_out  <= memData_in;
          mc_signed   <= memSigned_in;
        end
        BUSY: if (mcDone_in) begin
          load_buf  <= ext_data;
          mcReq_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op) state_nxt = BUSY;
      BUSY:    if (mcDone_in) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced to a bubble while reset is asserted, independent of inputs.
  always_comb begin
    stallReq_out = 1'b0;
    rdE_out      = writeDisable;
    rdIdx_out    = regNOP;
    rdData_out   = ZERO32;
    if (!rst_in) begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            stallReq_out = 1'b1;
          end else begin
            rdE_out    = rdE_in;
            rdIdx_out  = rdIdx_in;
            rdData_out = rdData_in;
          end
        end
        BUSY: stallReq_out = 1'b1;
        default: begin
          if (!mcWrite_out) begin
            rdE_out    = rdE_in;
            rdIdx_out  = rdIdx_in;
            rdData_out = load_buf;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for pass-through and loads,
// hand sequences for store, rdy_in freeze and mid-request reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        rd_e_i;
  logic [4:0]  rd_idx_i;
  logic [31:0] rd_data_i;
  logic        mem_load, mem_store, mem_signed;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata;
  logic        mc_req, mc_write;
  logic [31:0] mc_addr, mc_wdata;
  logic [1:0]  mc_width;
  logic        mc_done;
  logic [31:0] mc_rdata;
  logic        rd_e_o;
  logic [4:0]  rd_idx_o;
  logic [31:0] rd_data_o;
  logic        stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .REG_IDX_W(5)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .rdy_in       (rdy),
    .rdE_in       (rd_e_i),
    .rdIdx_in     (rd_idx_i),
    .rdData_in    (rd_data_i),
    .memLoad_in   (mem_load),
    .memStore_in  (mem_store),
    .memWidth_in  (mem_width),
    .memSigned_in (mem_signed),
    .memAddr_in   (mem_addr),
    .memData_in   (mem_wdata),
    .mcReq_out    (mc_req),
    .mcWrite_out  (mc_write),
    .mcAddr_out   (mc_addr),
    .mcWidth_out  (mc_width),
    .mcData_out   (mc_wdata),
    .mcDone_in    (mc_done),
    .mcData_in    (mc_rdata),
    .rdE_out      (rd_e_o),
    .rdIdx_out    (rd_idx_o),
    .rdData_out   (rd_data_o),
    .stallReq_out (stall)
  );

  typedef struct {
    logic        is_load;
    logic        rd_e;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] raw;
    int          wait_cyc;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_load = 0; mem_store = 0; mem_width = 2'b00; mem_signed = 0;
    mem_addr = 0; mem_wdata = 0; rd_e_i = 0; rd_idx_i = 0; rd_data_i = 0;
  endtask

  // Full load: IDLE cycle, BUSY for 1+wt cycles, then DONE with result.
  task automatic do_load(input string nm, input logic [1:0] w, input logic s,
                         input logic [31:0] raw, input int wt, input logic [31:0] exp);
    @(negedge clk);
    mem_load = 1; mem_width = w; mem_signed = s; mem_addr = 32'h100;
    rd_e_i = 1; rd_idx_i = 5'd7; rd_data_i = 32'hCAFE0000;
    #2;
    check({nm, " idle stall"}, stall, 1);
    check({nm, " idle bubble"}, rd_e_o, 0);
    check({nm, " idle no req"}, mc_req, 0);
    @(negedge clk); #2;
    check({nm, " busy req"}, mc_req, 1);
    check({nm, " busy write"}, mc_write, 0);
    check({nm, " busy addr"}, mc_addr, 32'h100);
    check({nm, " busy stall"}, stall, 1);
    for (int k = 0; k < wt; k++) begin
      @(negedge clk); #2;
      check({nm, " wait stall"}, stall, 1);
      check({nm, " wait req"}, mc_req, 1);
    end
    mc_done = 1; mc_rdata = raw;
    @(negedge clk);
    mc_done = 0; mc_rdata = 32'h5A5A5A5A;
    #2;
    check({nm, " done stall"}, stall, 0);
    check({nm, " done rdE"}, rd_e_o, 1);
    check({nm, " done rdIdx"}, rd_idx_o, 7);
    check({nm, " done data"}, rd_data_o, exp);
    check({nm, " done req"}, mc_req, 0);
    clear_inputs();
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 1, 5'd5,  32'h00001234, 2'b00, 0, 0, 0, 32'h00001234};
    vecs[1]  = '{0, 0, 5'd3,  32'hFFFFFFFF, 2'b00, 0, 0, 0, 32'hFFFFFFFF};
    vecs[2]  = '{0, 1, 5'd31, 32'h80000000, 2'b00, 0, 0, 0, 32'h80000000};
    vecs[3]  = '{1, 0, 0, 0, 2'b00, 1, 32'h000000F0, 1, 32'hFFFFFFF0};
    vecs[4]  = '{1, 0, 0, 0, 2'b00, 0, 32'h000000F0, 0, 32'h000000F0};
    vecs[5]  = '{1, 0, 0, 0, 2'b00, 1, 32'h1234567F, 0, 32'h0000007F};
    vecs[6]  = '{1, 0, 0, 0, 2'b01, 0, 32'hABCD8001, 2, 32'h00008001};
    vecs[7]  = '{1, 0, 0, 0, 2'b01, 1, 32'hABCD8001, 0, 32'hFFFF8001};
    vecs[8]  = '{1, 0, 0, 0, 2'b01, 1, 32'h00007FFF, 0, 32'h00007FFF};
    vecs[9]  = '{1, 0, 0, 0, 2'b10, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vecs[10] = '{1, 0, 0, 0, 2'b11, 1, 32'h80000001, 1, 32'h80000001};

    rst = 1; rdy = 1; mc_done = 0; mc_rdata = 0;
    clear_inputs();
    rd_e_i = 1; rd_idx_i = 5'd5; rd_data_i = 32'h1234;
    #2;
    check("reset rdE", rd_e_o, 0);
    check("reset rdData", rd_data_o, 0);
    check("reset stall", stall, 0);
    check("reset req", mc_req, 0);
    check("reset addr", mc_addr, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_load) begin
        do_load($sformatf("vec%0d", i), vecs[i].width, vecs[i].sgn, vecs[i].raw,
                vecs[i].wait_cyc, vecs[i].exp_data);
      end else begin
        @(negedge clk);
        clear_inputs();
        rd_e_i = vecs[i].rd_e; rd_idx_i = vecs[i].rd_idx; rd_data_i = vecs[i].rd_data;
        #2;
        check($sformatf("vec%0d rdE", i), rd_e_o, vecs[i].rd_e);
        check($sformatf("vec%0d rdIdx", i), rd_idx_o, vecs[i].rd_idx);
        check($sformatf("vec%0d rdData", i), rd_data_o, vecs[i].exp_data);
        check($sformatf("vec%0d stall", i), stall, 0);
        check($sformatf("vec%0d req", i), mc_req, 0);
      end
    end

    // Store word, completion in first BUSY cycle: 3 cycles IDLE/BUSY/DONE.
    @(negedge clk);
    clear_inputs();
    mem_store = 1; mem_width = 2'b10; mem_addr = 32'h200; mem_wdata = 32'h55AA;
    rd_e_i = 1; rd_idx_i = 5'd9; rd_data_i = 32'h77;
    #2;
    check("sw idle stall", stall, 1);
    @(negedge clk); #2;
    check("sw req", mc_req, 1);
    check("sw write", mc_write, 1);
    check("sw addr", mc_addr, 32'h200);
    check("sw data", mc_wdata, 32'h55AA);
    check("sw width", mc_width, 2'b10);
    mc_done = 1;
    @(negedge clk);
    mc_done = 0;
    #2;
    check("sw done stall", stall, 0);
    check("sw done rdE", rd_e_o, 0);
    check("sw done rdData", rd_data_o, 0);
    check("sw done req", mc_req, 0);
    clear_inputs();

    // rdy_in low for 4 cycles in BUSY with a spurious completion pulse.
    @(negedge clk);
    mem_load = 1; mem_width = 2'b10; mem_addr = 32'h300; rd_e_i = 1; rd_idx_i = 5'd4;
    @(negedge clk); #2;
    check("rdy busy req", mc_req, 1);
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mc_done = (i == 1); mc_rdata = 32'h11111111;
      #2;
      check("rdy0 stall", stall, 1);
      check("rdy0 req", mc_req, 1);
      check("rdy0 rdE", rd_e_o, 0);
    end
    mc_done = 0; rdy = 1;
    @(negedge clk); #2;
    check("rdy1 still busy", stall, 1);
    check("rdy1 req", mc_req, 1);
    mc_done = 1; mc_rdata = 32'h22222222;
    @(negedge clk);
    mc_done = 0;
    #2;
    check("rdy done stall", stall, 0);
    check("rdy done data", rd_data_o, 32'h22222222);
    check("rdy done idx", rd_idx_o, 4);
    clear_inputs();

    // Reset between edges while a request is outstanding.
    @(negedge clk);
    mem_load = 1; mem_width = 2'b10; mem_addr = 32'h400; rd_e_i = 1; rd_idx_i = 5'd3;
    @(negedge clk); #2;
    check("rst busy req", mc_req, 1);
    #1 rst = 1;
    #1;
    check("rst async req", mc_req, 0);
    check("rst async stall", stall, 0);
    check("rst async rdE", rd_e_o, 0);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    rd_e_i = 1; rd_idx_i = 5'd9; rd_data_i = 32'hBEEF;
    #2;
    check("post rst idle stall", stall, 0);
    check("post rst passthru", rd_data_o, 32'hBEEF);
    check("post rst req", mc_req, 0);
    do_load("post rst load", 2'b00, 1, 32'h00000080, 0, 32'hFFFFFF80);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
